// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO host sequencer:
//   - field widths (PHY address, register address, data word)
//   - frame constants: start bits, opcodes, write turnaround pattern
//   - per-phase reload values for the single bit counter
//   - sequencer state type
//   - mdio_header(): builds the 14-bit start/opcode/PHY/REG header
// -----------------------------------------------------------------------------
package mdio_pkg;

    localparam int PHY_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 16;
    localparam int HDR_W  = 14;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WR    = 2'b10;

    // Each phase loads the index of its first (most significant) bit and
    // counts down to 0, so the counter doubles as the bit select.
    localparam logic [5:0] HDR_LOAD  = 6'(HDR_W - 1);
    localparam logic [5:0] TA_LOAD   = 6'd1;
    localparam logic [5:0] DATA_LOAD = 6'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } mdio_state_t;

    // Header in transmit order: bit 13 goes out first.
    function automatic logic [HDR_W-1:0] mdio_header(
        input logic             isWrite,
        input logic [PHY_W-1:0] phyAddr,
        input logic [REG_W-1:0] regAddr
    );
        return {ST, (isWrite ? OP_WRITE : OP_READ), phyAddr, regAddr};
    endfunction

endpackage

// File: rtl/mdio_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_rr_arbiter
// Two-way round-robin arbiter. When both requesters are valid the one that
// was not served last wins; a lone valid requester always wins.
// Ports:
//   i_clk     - clock (MDC)
//   i_rst_n   - asynchronous active-low reset
//   i_valid   - request valids, bit n = requester n
//   i_enable  - arbitration allowed this cycle (sequencer idle)
//   o_grant   - one-hot grant, combinational, zero when disabled
// -----------------------------------------------------------------------------
module mdio_rr_arbiter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    // Index of the requester served most recently. Resets to 1 so that
    // requester 0 wins the first contended arbitration.
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (o_grant != 2'b00) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/mdio_host_sequencer.sv
// -----------------------------------------------------------------------------
// mdio_host_sequencer
// MDIO (clause 22) management frame generator shared by two requesters.
// A granted request is serialised as: optional preamble of PRE_LEN ones,
// 14-bit header, 2-bit turnaround and 16 data bits, one bit per MDC cycle.
// Writes drive the whole frame; reads release the line for turnaround and
// data and shift MDIO_IN in at the end of each data cycle.
// Parameters:
//   PRE_LEN     - preamble length in bits (0..32)
// Ports:
//   MDC         - clock, all state changes on the rising edge
//   RESET       - asynchronous active-low reset
//   REQn_VALID  - requester n has a pending transaction
//   REQn_WRITE  - 1 = write, 0 = read
//   REQn_PHY    - PHY address
//   REQn_REG    - register address
//   REQn_WDATA  - write data
//   GNT         - one-cycle grant pulse, bit n = requester n
//   BUSY        - frame in progress (grant cycle through done cycle)
//   MDIO_OUT    - serial data toward the PHY (1 whenever not driving)
//   MDIO_OE     - drive enable for MDIO_OUT
//   MDIO_IN     - serial data from the PHY
//   RD_DATA     - result of the last completed read
//   DONE_VLD    - one-cycle completion pulse
//   DONE_ID     - requester the completion belongs to
// -----------------------------------------------------------------------------
module mdio_host_sequencer
    import mdio_pkg::*;
#(
    parameter int PRE_LEN = 0
) (
    input  logic              MDC,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    input  logic              REQ0_WRITE,
    input  logic [PHY_W-1:0]  REQ0_PHY,
    input  logic [REG_W-1:0]  REQ0_REG,
    input  logic [DATA_W-1:0] REQ0_WDATA,
    input  logic              REQ1_VALID,
    input  logic              REQ1_WRITE,
    input  logic [PHY_W-1:0]  REQ1_PHY,
    input  logic [REG_W-1:0]  REQ1_REG,
    input  logic [DATA_W-1:0] REQ1_WDATA,
    output logic [1:0]        GNT,
    output logic              BUSY,
    output logic              MDIO_OUT,
    output logic              MDIO_OE,
    input  logic              MDIO_IN,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              DONE_VLD,
    output logic              DONE_ID
);

    localparam bit         HAS_PRE  = (PRE_LEN > 0);
    localparam logic [5:0] PRE_LOAD = HAS_PRE ? 6'(PRE_LEN - 1) : 6'd0;

    mdio_state_t       r_state;
    logic [5:0]        r_cnt;
    logic [1:0]        r_gnt;
    logic              r_id;
    logic              r_write;
    logic [PHY_W-1:0]  r_phy;
    logic [REG_W-1:0]  r_regAddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-2:0] r_rxShift;
    logic [DATA_W-1:0] r_rdData;

    logic              w_idle;
    logic [1:0]        w_grant;
    logic              w_grantAny;
    logic              w_selWrite;
    logic [PHY_W-1:0]  w_selPhy;
    logic [REG_W-1:0]  w_selReg;
    logic [DATA_W-1:0] w_selWdata;
    logic [HDR_W-1:0]  w_hdr;
    logic              w_oe;
    logic              w_bit;
    logic              w_cntZero;

    assign w_idle     = (r_state == S_IDLE);
    assign w_grantAny = (w_grant != 2'b00);
    assign w_cntZero  = (r_cnt == 6'd0);
    assign w_hdr      = mdio_header(r_write, r_phy, r_regAddr);

    // Arbitration only happens while idle, which also guarantees that valid
    // changes during a frame cannot disturb it.
    mdio_rr_arbiter u_arb (
        .i_clk    (MDC),
        .i_rst_n  (RESET),
        .i_valid  ({REQ1_VALID, REQ0_VALID}),
        .i_enable (w_idle),
        .o_grant  (w_grant)
    );

    // Select the winning requester's fields for capture on the grant edge.
    always_comb begin
        w_selWrite = REQ0_WRITE;
        w_selPhy   = REQ0_PHY;
        w_selReg   = REQ0_REG;
        w_selWdata = REQ0_WDATA;
        if (w_grant[1]) begin
            w_selWrite = REQ1_WRITE;
            w_selPhy   = REQ1_PHY;
            w_selReg   = REQ1_REG;
            w_selWdata = REQ1_WDATA;
        end
    end

    // Frame sequencing. The single counter holds the index of the bit being
    // sent in the current phase and is reloaded whenever the phase changes.
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantAny) begin
                        if (HAS_PRE) begin
                            r_state <= S_PRE;
                            r_cnt   <= PRE_LOAD;
                        end else begin
                            r_state <= S_HDR;
                            r_cnt   <= HDR_LOAD;
                        end
                    end
                end
                S_PRE: begin
                    if (w_cntZero) begin
                        r_state <= S_HDR;
                        r_cnt   <= HDR_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_HDR: begin
                    if (w_cntZero) begin
                        r_state <= S_TA;
                        r_cnt   <= TA_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_TA: begin
                    if (w_cntZero) begin
                        r_state <= S_DATA;
                        r_cnt   <= DATA_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DATA: begin
                    if (w_cntZero) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 6'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

    // The grant pulse lands in the first frame cycle, alongside the
    // captured transaction fields.
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            r_gnt     <= 2'b00;
            r_id      <= 1'b0;
            r_write   <= 1'b0;
            r_phy     <= '0;
            r_regAddr <= '0;
            r_wdata   <= '0;
        end else begin
            r_gnt <= w_grant;
            if (w_grantAny) begin
                r_id      <= w_grant[1];
                r_write   <= w_selWrite;
                r_phy     <= w_selPhy;
                r_regAddr <= w_selReg;
                r_wdata   <= w_selWdata;
            end
        end
    end

    // Read data is sampled on the edge ending each data cycle. The final bit
    // bypasses the shifter so RD_DATA is complete on entry to DONE, and the
    // shifter only needs to hold the first fifteen bits.
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            r_rxShift <= '0;
            r_rdData  <= '0;
        end else if ((r_state == S_DATA) && !r_write) begin
            r_rxShift <= {r_rxShift[DATA_W-3:0], MDIO_IN};
            if (w_cntZero) begin
                r_rdData <= {r_rxShift, MDIO_IN};
            end
        end
    end

    // Serial output: the header and data bits are picked directly by the
    // counter; reads release the line from turnaround onward.
    always_comb begin
        w_oe  = 1'b0;
        w_bit = 1'b1;
        case (r_state)
            S_PRE: begin
                w_oe  = 1'b1;
                w_bit = 1'b1;
            end
            S_HDR: begin
                w_oe  = 1'b1;
                w_bit = w_hdr[r_cnt[3:0]];
            end
            S_TA: begin
                w_oe  = r_write;
                w_bit = TA_WR[r_cnt[0]];
            end
            S_DATA: begin
                w_oe  = r_write;
                w_bit = r_wdata[r_cnt[3:0]];
            end
            default: begin
                w_oe  = 1'b0;
                w_bit = 1'b1;
            end
        endcase
    end

    assign MDIO_OE  = w_oe;
    assign MDIO_OUT = w_oe ? w_bit : 1'b1;
    assign GNT      = r_gnt;
    assign BUSY     = !w_idle;
    assign RD_DATA  = r_rdData;
    assign DONE_VLD = (r_state == S_DONE);
    assign DONE_ID  = r_id;

endmodule

// File: doc/mdio_host_sequencer.md
MDIO_HOST_SEQUENCER -- requirements
Module: mdio_host_sequencer

Interface
REQ-001 SHALL have parameter PRE_LEN, default 0: number of preamble '1' bits sent before each frame (range 0..32).
REQ-002 SHALL have port MDC, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports REQ0_VALID / REQ1_VALID, input, 1 each: requester n has a pending transaction.
REQ-005 SHALL have ports REQ0_WRITE / REQ1_WRITE, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports REQ0_PHY / REQ1_PHY, input, 5 each: PHY address.
REQ-007 SHALL have ports REQ0_REG / REQ1_REG, input, 5 each: register address.
REQ-008 SHALL have ports REQ0_WDATA / REQ1_WDATA, input, 16 each: write data.
REQ-009 SHALL have port GNT, output, 2: one-cycle grant pulse, bit n = requester n.
REQ-010 SHALL have port BUSY, output, 1: a transaction is in progress.
REQ-011 SHALL have port MDIO_OUT, output, 1: serial management data to the PHY.
REQ-012 SHALL have port MDIO_OE, output, 1: MDIO_OUT drive enable.
REQ-013 SHALL have port MDIO_IN, input, 1: serial data from the PHY.
REQ-014 SHALL have port RD_DATA, output, 16: last completed read result.
REQ-015 SHALL have ports DONE_VLD, output, 1, and DONE_ID, output, 1: one-cycle completion pulse and the requester it belongs to.

Function
REQ-016 SHALL implement states IDLE, PRE, HDR, TA, DATA, DONE.
REQ-017 In IDLE with any REQn_VALID, SHALL grant one requester: GNT[n]=1 for exactly the next cycle, capture that requester's WRITE/PHY/REG/WDATA on the same edge, and move to PRE (to HDR when PRE_LEN=0).
REQ-018 Arbitration SHALL be round-robin: if both are valid, the requester not served last wins; a single valid requester always wins.
REQ-019 Requesters SHALL hold fields stable while VALID=1; a VALID dropped before grant withdraws the request without error.
REQ-020 One bit SHALL be emitted per MDC cycle, MSB first, with MDIO_OE=1 during PRE, HDR, and write TA/DATA.
REQ-021 HDR SHALL send 14 bits: start 01, opcode (write 01, read 10), PHY[4:0], REG[4:0].
REQ-022 Write TA SHALL drive 1 then 0; write DATA SHALL drive WDATA[15:0].
REQ-023 Read TA and DATA SHALL hold MDIO_OE=0 for 18 cycles; MDIO_IN SHALL be sampled at the end of each of the 16 DATA cycles, MSB first.
REQ-024 DONE SHALL last one cycle: DONE_VLD=1, DONE_ID=granted requester, MDIO_OE=0; for reads, RD_DATA SHALL update on entry to DONE; for writes, RD_DATA SHALL be unchanged.
REQ-025 After DONE, SHALL return to IDLE; at least one IDLE cycle (MDIO_OE=0, MDIO_OUT=1) SHALL separate frames.
REQ-026 Total OE-high cycles SHALL be PRE_LEN+32 for a write and PRE_LEN+14 for a read.
REQ-027 When MDIO_OE=0, MDIO_OUT SHALL be 1.
REQ-028 BUSY SHALL be 1 from the GNT cycle through the DONE cycle, inclusive.
REQ-029 REQn_VALID changes mid-frame SHALL not affect the current frame.

Reset
REQ-030 On RESET=0, SHALL set state IDLE immediately, GNT=0, BUSY=0, MDIO_OE=0, MDIO_OUT=1, RD_DATA=0, DONE_VLD=0, DONE_ID=0, last-served=1 (requester 0 wins first), including when reset occurs mid-frame.

Structure
REQ-031 Package mdio_pkg SHALL hold the state enum, ST=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, TA_WR=2'b10, and widths PHY_W=5, REG_W=5, DATA_W=16.
REQ-032 The 2-way round-robin SHALL be sub-module mdio_rr_arbiter (inputs: valids, enable; outputs: one-hot grant; internal last-served register).
REQ-033 The shift/bit counter SHALL be a single 6-bit counter reloaded per state.

Verification
REQ-034 Write, PRE_LEN=0: REQ0 write PHY=7 REG=0x0B WDATA=0x43AE -> serial 01 01 00111 01011 10 0100001110101110, 32 OE-high cycles, DONE_VLD with DONE_ID=0.
REQ-035 Read: REQ1 read PHY=3 REG=0x0B, PHY model drives 0xBEEF -> 14 OE-high cycles (01 10 00011 01011), 18 OE-low cycles, RD_DATA=0xBEEF, DONE_ID=1.
REQ-036 Contention: both valid from reset -> grants 0,1,0,1 in order, each frame complete, one or more IDLE cycles between frames.
REQ-037 PRE_LEN=32: any write -> 32 '1' bits precede start bits; 64 OE-high cycles in total.
REQ-038 Reset mid-frame: assert RESET=0 during write DATA bit 5 -> MDIO_OE=0, MDIO_OUT=1, BUSY=0 at once, no DONE_VLD; the next request goes to requester 0.
REQ-039 Write after read: RD_DATA keeps the prior read value across a write DONE.
